// File: rtl/fpu_sequencer.sv
// fpu_sequencer: issues one decoded single-precision FPU instruction at a time
// to the shared fadd_fsub / fmul / fdiv units, waits the selected unit's fixed
// latency, then produces a one-cycle write-back to the float register file.
//
// Ports:
//   CLK, RST_N                  clock, asynchronous active-low reset
//   req_valid/req_ready         core issue handshake
//   req_op/req_fd/req_fs/req_ft decoded op, destination index, source values
//   add_a/add_b/add_sub         fadd_fsub operands, add_result its result
//   mul_a/mul_b, mul_result     fmul operands and result
//   div_a/div_b, div_result     fdiv operands and result
//   wb_valid/wb_fd/wb_data      one-cycle write-back strobe, index, value
//   busy                        operation executing
//   illegal                     one-cycle pulse for an undecodable op
//   op_count                    completed write-backs, wrapping
module fpu_sequencer #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 28
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_fd,
  input  logic [31:0] req_fs,
  input  logic [31:0] req_ft,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_sub,
  input  logic [31:0] add_result,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_result,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_result,
  output logic        wb_valid,
  output logic [4:0]  wb_fd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] op_count
);

  localparam int unsigned OP_W   = 3;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned OPC_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_MUL = 3'b010;
  localparam logic [OP_W-1:0] OP_DIV = 3'b011;
  localparam logic [OP_W-1:0] OP_MOV = 3'b110;

  // Counter preloads: EXEC lasts exactly LAT cycles (cnt runs LAT-1 .. 0).
  localparam logic [CNT_W-1:0] ADD_LOAD = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [REG_W-1:0]    fd_q, fd_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                add_sub_q, add_sub_d;
  logic                wb_valid_q, wb_valid_d;
  logic [REG_W-1:0]    wb_fd_q, wb_fd_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                illegal_q, illegal_d;
  logic [OPC_W-1:0]    op_count_q, op_count_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;

  logic                accept_c;
  logic [DATA_W-1:0]   unit_result_c;

  // Result of the unit selected by the latched op.
  always_comb begin
    unit_result_c = add_result;
    case (op_q)
      OP_MUL:  unit_result_c = mul_result;
      OP_DIV:  unit_result_c = div_result;
      default: unit_result_c = add_result;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fd_d       = fd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    cnt_d      = cnt_q;
    add_sub_d  = add_sub_q;
    wb_valid_d = 1'b0;
    wb_fd_d    = wb_fd_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    op_count_d = op_count_q;
    accept_c   = req_valid && req_ready_q;

    case (state_q)
      S_EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          wb_data_d  = unit_result_c;
          wb_fd_d    = fd_q;
          wb_valid_d = 1'b1;
          op_count_d = op_count_q + OPC_W'(1);
          state_d    = S_WB;
        end
      end
      default: begin
        // IDLE and WB both accept; WB without a new request falls back to IDLE.
        state_d = S_IDLE;
        if (accept_c) begin
          op_d      = req_op;
          fd_d      = req_fd;
          op_a_d    = req_fs;
          op_b_d    = req_ft;
          add_sub_d = (req_op == OP_SUB);
          case (req_op)
            OP_ADD, OP_SUB: begin
              cnt_d   = ADD_LOAD;
              state_d = S_EXEC;
            end
            OP_MUL: begin
              cnt_d   = MUL_LOAD;
              state_d = S_EXEC;
            end
            OP_DIV: begin
              cnt_d   = DIV_LOAD;
              state_d = S_EXEC;
            end
            OP_MOV: begin
              wb_data_d  = req_ft;
              wb_fd_d    = req_fd;
              wb_valid_d = 1'b1;
              op_count_d = op_count_q + OPC_W'(1);
              state_d    = S_WB;
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = S_IDLE;
            end
          endcase
        end
      end
    endcase

    req_ready_d = (state_d != S_EXEC);
    busy_d      = (state_d == S_EXEC);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      fd_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      cnt_q       <= '0;
      add_sub_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_fd_q     <= '0;
      wb_data_q   <= '0;
      illegal_q   <= 1'b0;
      op_count_q  <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fd_q        <= fd_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      cnt_q       <= cnt_d;
      add_sub_q   <= add_sub_d;
      wb_valid_q  <= wb_valid_d;
      wb_fd_q     <= wb_fd_d;
      wb_data_q   <= wb_data_d;
      illegal_q   <= illegal_d;
      op_count_q  <= op_count_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // All three units see the same latched operands.
  assign add_a     = op_a_q;
  assign add_b     = op_b_q;
  assign add_sub   = add_sub_q;
  assign mul_a     = op_a_q;
  assign mul_b     = op_b_q;
  assign div_a     = op_a_q;
  assign div_b     = op_b_q;
  assign wb_valid  = wb_valid_q;
  assign wb_fd     = wb_fd_q;
  assign wb_data   = wb_data_q;
  assign illegal   = illegal_q;
  assign op_count  = op_count_q;
  assign req_ready = req_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: table of single-op vectors plus
// hand-written sequences for hold-during-EXEC, back-to-back issue, reset
// during EXEC and op_count wrap. Unit results come from small lookup models
// that only return the right value once operands have been stable LAT cycles.
module tb_fpu_sequencer;

  localparam int unsigned ADD_LAT = 1;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 28;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOV = 3'b110;

  logic        CLK;
  logic        RST_N;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_fd;
  logic [31:0] req_fs;
  logic [31:0] req_ft;
  logic [31:0] add_a, add_b, add_result;
  logic        add_sub;
  logic [31:0] mul_a, mul_b, mul_result;
  logic [31:0] div_a, div_b, div_result;
  logic        wb_valid;
  logic [4:0]  wb_fd;
  logic [31:0] wb_data;
  logic        busy;
  logic        illegal;
  logic [15:0] op_count;

  int n_pass  = 0;
  int n_total = 0;
  int exp_count = 0;

  fpu_sequencer #(
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_fd(req_fd), .req_fs(req_fs), .req_ft(req_ft),
    .add_a(add_a), .add_b(add_b), .add_sub(add_sub), .add_result(add_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_a(div_a), .div_b(div_b), .div_result(div_result),
    .wb_valid(wb_valid), .wb_fd(wb_fd), .wb_data(wb_data),
    .busy(busy), .illegal(illegal), .op_count(op_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Unit models: known single-precision results for the vectors used here.
  function automatic logic [31:0] f_add(logic [31:0] a, logic [31:0] b, logic sub);
    if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (!sub && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
    if (sub && a == 32'h4040_0000 && b == 32'h3F80_0000)  return 32'h4000_0000;
    return 32'hBAD0_0A00;
  endfunction

  function automatic logic [31:0] f_mul(logic [31:0] a, logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return 32'hBAD0_0B00;
  endfunction

  function automatic logic [31:0] f_div(logic [31:0] a, logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h3F00_0000;
    return 32'hBAD0_0C00;
  endfunction

  // Operand age: cycles the unit operands have been stable.
  logic [192:0] ops_last = '0;
  int age = 0;
  always @(negedge CLK) begin
    if ({add_a, add_b, add_sub, mul_a, mul_b, div_a, div_b} != ops_last) begin
      ops_last = {add_a, add_b, add_sub, mul_a, mul_b, div_a, div_b};
      age = 1;
    end else if (age < 1000) begin
      age = age + 1;
    end
  end

  always_comb begin
    add_result = (age >= int'(ADD_LAT)) ? f_add(add_a, add_b, add_sub) : 32'hDEAD_0A00;
    mul_result = (age >= int'(MUL_LAT)) ? f_mul(mul_a, mul_b) : 32'hDEAD_0B00;
    div_result = (age >= int'(DIV_LAT)) ? f_div(div_a, div_b) : 32'hDEAD_0C00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_wb_valid"},  32'(wb_valid),  32'd0);
    chk({tag, "_illegal"},   32'(illegal),   32'd0);
    chk({tag, "_wb_fd"},     32'(wb_fd),     32'd0);
    chk({tag, "_wb_data"},   wb_data,        32'd0);
    chk({tag, "_op_count"},  32'(op_count),  32'd0);
    chk({tag, "_add_a"},     add_a,          32'd0);
    chk({tag, "_mul_b"},     mul_b,          32'd0);
    chk({tag, "_div_a"},     div_a,          32'd0);
    chk({tag, "_add_sub"},   32'(add_sub),   32'd0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [4:0]  fd;
    logic [31:0] fs;
    logic [31:0] ft;
    int          wb_at;   // negedge after accept with wb_valid, 0 = none
    logic [31:0] data;
    int          busy_n;
    int          ill_n;
  } vec_t;

  // Issue one op, watch 35 cycles, compare against the record.
  task automatic run_vec(input vec_t v);
    int first_wb = 0;
    int wb_n = 0, busy_n = 0, rdy_low = 0, ill_n = 0;
    logic [31:0] d = '0;
    logic [4:0]  f = '0;
    @(negedge CLK);
    chk({v.name, "_ready_pre"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = v.op; req_fd = v.fd; req_fs = v.fs; req_ft = v.ft;
    @(posedge CLK);
    for (int c = 1; c <= 35; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        req_valid = 1'b0;
        if (v.op == OP_ADD || v.op == OP_SUB)
          chk({v.name, "_add_sub"}, 32'(add_sub), 32'(v.op == OP_SUB));
      end
      if (wb_valid) begin
        wb_n++;
        if (first_wb == 0) begin first_wb = c; d = wb_data; f = wb_fd; end
      end
      if (busy) busy_n++;
      if (!req_ready) rdy_low++;
      if (illegal) ill_n++;
    end
    if (v.wb_at != 0) exp_count++;
    chk({v.name, "_wb_at"},   32'(first_wb), 32'(v.wb_at));
    chk({v.name, "_wb_n"},    32'(wb_n),     32'(v.wb_at != 0));
    if (v.wb_at != 0) begin
      chk({v.name, "_wb_data"}, d, v.data);
      chk({v.name, "_wb_fd"},   32'(f), 32'(v.fd));
    end
    chk({v.name, "_busy_n"},  32'(busy_n),   32'(v.busy_n));
    chk({v.name, "_rdy_low"}, 32'(rdy_low),  32'(v.busy_n));
    chk({v.name, "_ill_n"},   32'(ill_n),    32'(v.ill_n));
    chk({v.name, "_op_count"}, 32'(op_count), 32'(exp_count[15:0]));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, checks passed %0d of %0d", n_pass, n_total);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    int wb_c[4];
    logic [31:0] wb_d[4];
    logic [4:0]  wb_f[4];
    int n_wb;
    int busy_n;

    RST_N = 1'b1; req_valid = 1'b0; req_op = '0; req_fd = '0; req_fs = '0; req_ft = '0;
    #1 RST_N = 1'b0;
    #11;
    chk_reset_vals("rst");
    @(negedge CLK);
    RST_N = 1'b1;

    vecs[0] = '{"add",   OP_ADD, 5'd5,  32'h3F80_0000, 32'h4000_0000, ADD_LAT+1, 32'h4040_0000, ADD_LAT, 0};
    vecs[1] = '{"sub",   OP_SUB, 5'd2,  32'h4040_0000, 32'h3F80_0000, ADD_LAT+1, 32'h4000_0000, ADD_LAT, 0};
    vecs[2] = '{"mul",   OP_MUL, 5'd9,  32'h4000_0000, 32'h4040_0000, MUL_LAT+1, 32'h40C0_0000, MUL_LAT, 0};
    vecs[3] = '{"div",   OP_DIV, 5'd31, 32'h40C0_0000, 32'h4000_0000, DIV_LAT+1, 32'h4040_0000, DIV_LAT, 0};
    vecs[4] = '{"mov",   OP_MOV, 5'd1,  32'h1111_2222, 32'hDEAD_BEEF, 1,         32'hDEAD_BEEF, 0,       0};
    vecs[5] = '{"ill7",  3'b111, 5'd4,  32'h3F80_0000, 32'h4000_0000, 0,         32'h0,         0,       1};
    vecs[6] = '{"ill4",  3'b100, 5'd6,  32'h0,         32'h0,         0,         32'h0,         0,       1};
    vecs[7] = '{"add2",  OP_ADD, 5'd0,  32'h4000_0000, 32'h4000_0000, ADD_LAT+1, 32'h4080_0000, ADD_LAT, 0};
    vecs[8] = '{"ill5",  3'b101, 5'd7,  32'h1,         32'h2,         0,         32'h0,         0,       1};
    vecs[9] = '{"div2",  OP_DIV, 5'd3,  32'h3F80_0000, 32'h4000_0000, DIV_LAT+1, 32'h3F00_0000, DIV_LAT, 0};

    foreach (vecs[i]) run_vec(vecs[i]);

    // DIV with a MOV held during EXEC: MOV accepted only in the WB cycle.
    n_wb = 0; busy_n = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_op = OP_DIV; req_fd = 5'd31; req_fs = 32'h40C0_0000; req_ft = 32'h4000_0000;
    @(posedge CLK);
    for (int c = 1; c <= 40; c++) begin
      @(negedge CLK);
      if (c == 1) begin req_op = OP_MOV; req_fd = 5'd7; req_ft = 32'h1234_5678; end
      if (c == 30) req_valid = 1'b0;
      if (busy) busy_n++;
      if (wb_valid) begin
        if (n_wb < 4) begin wb_c[n_wb] = c; wb_d[n_wb] = wb_data; wb_f[n_wb] = wb_fd; end
        n_wb++;
      end
    end
    exp_count += 2;
    chk("hold_wb_n", 32'(n_wb), 32'd2);
    chk("hold_busy_n", 32'(busy_n), 32'(DIV_LAT));
    if (n_wb >= 2) begin
      chk("hold_div_at",   32'(wb_c[0]), 32'(DIV_LAT + 1));
      chk("hold_div_data", wb_d[0], 32'h4040_0000);
      chk("hold_div_fd",   32'(wb_f[0]), 32'd31);
      chk("hold_mov_at",   32'(wb_c[1]), 32'(DIV_LAT + 2));
      chk("hold_mov_data", wb_d[1], 32'h1234_5678);
      chk("hold_mov_fd",   32'(wb_f[1]), 32'd7);
    end
    chk("hold_op_count", 32'(op_count), 32'(exp_count[15:0]));

    // MOV then SUB issued in the MOV's WB cycle.
    @(negedge CLK);
    req_valid = 1'b1; req_op = OP_MOV; req_fd = 5'd1; req_fs = 32'h0; req_ft = 32'hDEAD_BEEF;
    @(posedge CLK);
    @(negedge CLK);
    chk("b2b_mov_valid", 32'(wb_valid), 32'd1);
    chk("b2b_mov_fd",    32'(wb_fd),    32'd1);
    chk("b2b_mov_data",  wb_data,       32'hDEAD_BEEF);
    chk("b2b_wb_ready",  32'(req_ready), 32'd1);
    req_op = OP_SUB; req_fd = 5'd2; req_fs = 32'h4040_0000; req_ft = 32'h3F80_0000;
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("b2b_exec_valid", 32'(wb_valid), 32'd0);
    chk("b2b_exec_busy",  32'(busy),     32'd1);
    chk("b2b_exec_sub",   32'(add_sub),  32'd1);
    chk("b2b_exec_ready", 32'(req_ready), 32'd0);
    @(negedge CLK);
    chk("b2b_sub_valid", 32'(wb_valid), 32'd1);
    chk("b2b_sub_data",  wb_data,       32'h4000_0000);
    chk("b2b_sub_fd",    32'(wb_fd),    32'd2);
    exp_count += 2;
    chk("b2b_op_count",  32'(op_count), 32'(exp_count[15:0]));
    @(negedge CLK);
    chk("b2b_after_valid", 32'(wb_valid), 32'd0);

    // Reset at EXEC cycle 10 of a DIV.
    @(negedge CLK);
    req_valid = 1'b1; req_op = OP_DIV; req_fd = 5'd12; req_fs = 32'h40C0_0000; req_ft = 32'h4000_0000;
    @(posedge CLK);
    n_wb = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 1) req_valid = 1'b0;
      if (wb_valid) n_wb++;
    end
    RST_N = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (wb_valid) n_wb++;
    end
    chk("rst_div_no_wb", 32'(n_wb), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    exp_count = 0;

    // 65536 consecutive MOVs: op_count wraps back to zero.
    n_wb = 0;
    @(negedge CLK);
    req_valid = 1'b1; req_op = OP_MOV; req_fd = 5'd4; req_fs = 32'h0; req_ft = 32'hA5A5_5A5A;
    for (int i = 1; i <= 65536; i++) begin
      @(negedge CLK);
      if (wb_valid) n_wb++;
      if (i == 65535) chk("wrap_ffff", 32'(op_count), 32'h0000_FFFF);
    end
    req_valid = 1'b0;
    chk("wrap_wb_n", 32'(n_wb), 32'd65536);
    chk("wrap_zero", 32'(op_count), 32'd0);
    @(negedge CLK);
    chk("wrap_after_valid", 32'(wb_valid), 32'd0);
    chk("wrap_after_count", 32'(op_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
